// File: rtl/muldiv_sequencer_pkg.sv
// rtl/muldiv_sequencer_pkg.sv - shared widths, RV32M funct3 encodings and FSM states for the muldiv unit
package muldiv_sequencer_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - shared shift/add/subtract datapath with sign fix-up; MULDIV_EARLY_OUT_EN preloads special results
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            early_hit,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   b_q;
    logic [2:0]        f3_q;
    logic              neg_p_q;
    logic              neg_q_q;
    logic              neg_r_q;

    logic              op1_signed;
    logic              op2_signed;
    logic              s1;
    logic              s2;
    logic              is_div;
    logic              div_zero;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;

    assign op1_signed = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    assign op2_signed = op1_signed && (funct3 != F3_MULHSU);
    assign s1         = op1_signed && op1[XLEN-1];
    assign s2         = op2_signed && op2[XLEN-1];
    assign mag1       = s1 ? -op1 : op1;
    assign mag2       = s2 ? -op2 : op2;
    assign is_div     = funct3[2];
    assign div_zero   = is_div && (op2 == '0);

`ifdef MULDIV_EARLY_OUT_EN
    logic ovf;
    logic mul_zero;
    assign ovf       = is_div && !funct3[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign mul_zero  = !is_div && ((op1 == '0) || (op2 == '0));
    assign early_hit = div_zero || ovf || mul_zero;
`else
    assign early_hit = 1'b0;
`endif

    // Multiply: upper half accumulates, lower half shifts the multiplier out LSB first.
    // Divide: upper half is the remainder, lower half shifts dividend out and quotient in.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_trial;
    logic            q_bit;
    logic [XLEN-1:0] rem_next;

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    assign div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    // div_shift < 2*divisor always, so bit XLEN of the 33-bit difference is the borrow.
    assign div_trial = div_shift - {1'b0, b_q};
    assign q_bit     = ~div_trial[XLEN];
    assign rem_next  = q_bit ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            neg_p_q <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (load) begin
            f3_q    <= funct3;
            neg_p_q <= s1 ^ s2;
            // Divide-by-zero yields an all-ones quotient regardless of operand signs.
            neg_q_q <= (s1 ^ s2) && !div_zero;
            neg_r_q <= s1;
            b_q     <= is_div ? mag2 : mag1;
            prod_q  <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
`ifdef MULDIV_EARLY_OUT_EN
            if (div_zero) begin
                prod_q <= {mag1, {XLEN{1'b1}}};
            end else if (ovf) begin
                prod_q <= {{XLEN{1'b0}}, op1};
            end else if (mul_zero) begin
                prod_q <= '0;
            end
`endif
        end else if (step) begin
            if (f3_q[2]) begin
                prod_q <= {rem_next, prod_q[XLEN-2:0], q_bit};
            end else begin
                prod_q <= {mul_sum, prod_q[XLEN-1:1]};
            end
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    assign prod_fix = neg_p_q ? -prod_q : prod_q;
    assign quot_fix = neg_q_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    assign rem_fix  = neg_r_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];

    always_comb begin
        result = rem_fix;
        case (f3_q)
            F3_MUL:                       result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result = quot_fix;
            default:                      result = rem_fix;
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer; MULDIV_EARLY_OUT_EN enables single-cycle special cases
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic            i_CLK,
    input  logic            i_RST,
    input  logic            i_Start,
    input  logic            i_Kill,
    input  logic [2:0]      i_Funct3,
    input  logic [XLEN-1:0] i_Op1,
    input  logic [XLEN-1:0] i_Op2,
    output logic            o_Busy,
    output logic            o_Valid,
    output logic [XLEN-1:0] o_Result
);

    logic [1:0]      state;
    logic [5:0]      cnt;
    logic            dp_load;
    logic            dp_step;
    logic            early_hit;
    logic [XLEN-1:0] dp_result;

    assign dp_load = (state == ST_IDLE) && i_Start && !i_Kill;
    assign dp_step = (state == ST_CALC) && !i_Kill;

    muldiv_datapath u_datapath (
        .clk       (i_CLK),
        .rst       (i_RST),
        .load      (dp_load),
        .step      (dp_step),
        .funct3    (i_Funct3),
        .op1       (i_Op1),
        .op2       (i_Op2),
        .early_hit (early_hit),
        .result    (dp_result)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            o_Busy   <= 1'b0;
            o_Valid  <= 1'b0;
            o_Result <= '0;
        end else begin
            o_Valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dp_load) begin
                        cnt    <= '0;
                        o_Busy <= 1'b1;
                        state  <= early_hit ? ST_FIX : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (i_Kill) begin
                        state  <= ST_IDLE;
                        o_Busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state  <= ST_IDLE;
                    o_Busy <= 1'b0;
                    if (!i_Kill) begin
                        o_Result <= dp_result;
                        o_Valid  <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 33;
`endif

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .i_CLK    (clk),
        .i_RST    (rst),
        .i_Start  (start),
        .i_Kill   (kill),
        .i_Funct3 (funct3),
        .i_Op1    (op1),
        .i_Op2    (op2),
        .o_Busy   (busy),
        .o_Valid  (valid),
        .o_Result (result)
    );

    // Issues one op (its posedge is edge 0), scrambles operands afterwards and
    // waits for o_Valid; lat = edges after edge 0, or -1 on timeout.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy0, output logic [31:0] res,
                          output logic busy_at_valid);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op1    = a;
        op2    = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op1    = $urandom;
        op2    = $urandom;
        funct3 = 3'($urandom_range(0, 7));
        busy0  = busy;
        lat    = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = n;
                break;
            end
        end
        res           = result;
        busy_at_valid = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op1 = '0; op2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, valid, result} !== 34'd0) begin
            errors++;
            $display("FAIL reset: busy=%b valid=%b result=%h want all 0", busy, valid, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors(input string tag, input logic [2:0] f3 [], input logic [31:0] a [],
                                input logic [31:0] b [], input logic [31:0] exp [], input int exp_lat);
        int lat; logic b0; logic [31:0] res; logic bv;
        for (int i = 0; i < f3.size(); i++) begin
            run_op(f3[i], a[i], b[i], lat, b0, res, bv);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL %s[%0d] result: got %h want %h", tag, i, res, exp[i]);
            end
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL %s[%0d] latency: got %0d want %0d", tag, i, lat, exp_lat);
            end
            checks++;
            if (b0 !== 1'b1 || bv !== 1'b0) begin
                errors++;
                $display("FAIL %s[%0d] busy: at start %b at valid %b want 1/0", tag, i, b0, bv);
            end
            @(posedge clk);
            #1;
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL %s[%0d] valid width: got %b want 0 one cycle later", tag, i, valid);
            end
        end
    endtask

    task automatic test_mul();
        test_vectors("mul", '{3'b000, 3'b001, 3'b011, 3'b010},
                     '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
                     '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF},
                     '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF}, 33);
    endtask

    task automatic test_div();
        test_vectors("div", '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101},
                     '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'd100},
                     '{32'd2, 32'd2, 32'd2, 32'd2, 32'd7},
                     '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd3, 32'd1, 32'd14}, 33);
    endtask

    task automatic test_special();
        test_vectors("special", '{3'b100, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110, 3'b000, 3'b001},
                     '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF},
                     '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd5, 32'd0},
                     '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd0, 32'd0}, SP_LAT);
    endtask

    task automatic test_kill();
        int lat; logic b0; logic [31:0] res; logic bv;
        logic [31:0] prior;
        logic seen_valid;
        run_op(3'b101, 32'd100, 32'd7, lat, b0, res, bv);
        prior = 32'd14;
        checks++;
        if (res !== prior) begin
            errors++;
            $display("FAIL kill_setup result: got %h want %h", res, prior);
        end
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; op1 = 32'd1000; op2 = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            seen_valid |= valid;
        end
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_abort: busy=%b valid=%b seen=%b want 0/0/0", busy, valid, seen_valid);
        end
        checks++;
        if (result !== prior) begin
            errors++;
            $display("FAIL kill_hold result: got %h want %h", result, prior);
        end
        run_op(3'b000, 32'd3, 32'd4, lat, b0, res, bv);
        checks++;
        if (res !== 32'd12 || lat !== 33) begin
            errors++;
            $display("FAIL kill_restart: result %h lat %0d want 0000000c lat 33", res, lat);
        end
        // Kill in IDLE must swallow a same-cycle start.
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'b000; op1 = 32'd2; op2 = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle busy: got %b want 0", busy);
        end
    endtask

    task automatic test_ignored_start_and_reset();
        logic seen_valid;
        logic [31:0] res;
        int lat;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; funct3 = 3'b000; op1 = 32'd9; op2 = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int n = 6; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = n;
                break;
            end
        end
        res = result;
        checks++;
        if (res !== 32'd14 || lat !== 33) begin
            errors++;
            $display("FAIL busy_start: result %h lat %0d want 0000000e lat 33", res, lat);
        end
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; op1 = 32'd77; op2 = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, valid, result} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b valid=%b result=%h want all 0", busy, valid, result);
        end
        seen_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen_valid |= valid | busy;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: activity=%b want 0", seen_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic b0; logic [31:0] res; logic bv;
        run_op(3'b000, 32'd6, 32'd7, lat, b0, res, bv);
        checks++;
        if (res !== 32'd42 || lat !== 33) begin
            errors++;
            $display("FAIL b2b_first: result %h lat %0d want 0000002a lat 33", res, lat);
        end
        // Next start is presented during the o_Valid cycle.
        run_op(3'b111, 32'd50, 32'd8, lat, b0, res, bv);
        checks++;
        if (res !== 32'd2 || lat !== 33 || b0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: result %h lat %0d busy %b want 00000002 lat 33 busy 1", res, lat, b0);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_kill();
        test_ignored_start_and_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage.
- Accepts an M-extension operation (funct7 = 0000001, selected by funct3) with two operands.
- Sequences a shared shift/add/subtract datapath for 32 iterations.
- Returns a 32-bit result with a one-cycle valid pulse.
- Holds busy high so the pipeline stalls until the result is available.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- i_CLK  in  1  clock, all logic on rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_Start  in  1  request; sampled only in IDLE.
- i_Kill  in  1  synchronous abort of the in-flight operation (pipeline flush).
- i_Funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_Op1  in  XLEN  rs1 value (multiplicand/dividend).
- i_Op2  in  XLEN  rs2 value (multiplier/divisor).
- o_Busy  out  1  high while an operation is in flight; reset 0.
- o_Valid  out  1  one-cycle result strobe; reset 0.
- o_Result  out  XLEN  result, held until the next o_Valid; reset 0.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, i_Start=1, i_Kill=0:
  - Latch funct3.
  - Latch operand magnitudes and result-sign flags.
  - Clear the 6-bit iteration counter; go to CALC; o_Busy <= 1.
- Operand signedness:
  - op1 signed for MUL/MULH/MULHSU/DIV/REM.
  - op2 signed for MUL/MULH/DIV/REM.
  - Magnitude = two's-complement negate when signed and negative.
- CALC multiply: shift-add, 64-bit product register, one multiplier bit per cycle, LSB first.
- CALC divide: restoring divide, 33-bit trial subtract, one quotient bit per cycle, MSB first; 32-bit remainder register.
- Counter increments each CALC cycle; after 32 iterations go to FIX.
- FIX:
  - Negate the product if the signs differ.
  - Negate the quotient if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Select low word for MUL, high word for MULH*, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register the selection into o_Result; o_Valid <= 1, o_Busy <= 0; go to IDLE.
- Special cases (RISC-V mandated):
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend (unsigned and signed).
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- i_Start while busy is ignored; no queueing.
- i_Kill in CALC or FIX: next state IDLE, o_Busy <= 0, no o_Valid, o_Result unchanged.
- i_Kill in IDLE: suppresses a same-cycle i_Start.
- i_Kill has priority over i_Start.
- i_RST has priority over everything: state IDLE, all outputs 0, counter 0.
- Operand inputs are ignored after the sampling edge; they may change freely.

## Timing
- Sampling edge = edge 0.
- Normal path:
  - CALC occupies edges 1..32.
  - FIX updates outputs at edge 33.
  - o_Valid is high for the cycle after edge 33.
- o_Busy is high from edge 0 through edge 33.
- A new i_Start is accepted in the same cycle o_Valid is high; back-to-back throughput is one op per 34 cycles.
- o_Valid never stays high more than one cycle.

## Configuration
- MULDIV_EARLY_OUT_EN defined:
  - At edge 0, detect divide-by-zero, signed overflow, and multiply with either operand zero.
  - On a hit, go directly to FIX with the special result preloaded; o_Valid at edge 1.
- MULDIV_EARLY_OUT_EN undefined:
  - Every op takes the full path; o_Valid at edge 33.
  - The special-case results above must still be produced, via natural datapath behaviour plus the FIX overflow/zero override.

## Structure
- Shared package/header holds:
  - XLEN.
  - funct3 encodings for the eight M ops.
  - F7_MULDIV = 7'b0000001.
  - FSM state encodings.
- Sub-module muldiv_datapath:
  - Holds the product/quotient/remainder registers, trial subtractor and negators.
  - Step/load/fix strobes come from the top-level FSM.
- The top level holds the FSM, counter and output registers.

## Test plan
- MUL 7 × 0xFFFFFFFD → o_Result 0xFFFFFFEB; o_Valid one cycle at edge 33; o_Busy low after.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 7 / 2 → 3; REMU 7 / 2 → 1.
- DIV 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0. Latency is edge 1 with MULDIV_EARLY_OUT_EN, edge 33 without.
- i_Kill at edge 10:
  - No o_Valid; o_Busy 0 next cycle; o_Result keeps the prior value.
  - A new MUL 3 × 4 started next cycle → 12.
- i_RST at edge 20 mid-DIV → all outputs 0 next cycle; i_Start pulsed during CALC has no effect on the result.
